// File: rtl/register_file_2r1w.sv
// register_file_2r1w: two registered read ports, one byte-strobed write port,
// out-of-range detection on every port. Storage and outputs clear on reset.
// Optional macro REGFILE_WR_BYPASS_EN: same-edge read/write to one in-range
// address returns the post-write value (write-first); default is read-first.

// One registered read port: data loads on en, valid/err are single-cycle pulses.
module regfile_rd_port #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         oor,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         err
);
  // data holds when idle; pulses drop back to 0 one cycle after a request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= en;
      err   <= en & oor;
      if (en) dout <= din;
    end
  end
endmodule

module register_file_2r1w #(
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_DEPTH  = 16,
  parameter int MEM_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   WrEn,
  input  logic [ADDR_WIDTH-1:0]  WrAddr,
  input  logic [MEM_WIDTH/8-1:0] WrStrb,
  input  logic [MEM_WIDTH-1:0]   WrData,
  output logic                   WrErr,
  input  logic                   RdEnA,
  input  logic [ADDR_WIDTH-1:0]  RdAddrA,
  output logic [MEM_WIDTH-1:0]   RdDataA,
  output logic                   RdValidA,
  output logic                   RdErrA,
  input  logic                   RdEnB,
  input  logic [ADDR_WIDTH-1:0]  RdAddrB,
  output logic [MEM_WIDTH-1:0]   RdDataB,
  output logic                   RdValidB,
  output logic                   RdErrB
);
  localparam int NB = MEM_WIDTH / 8;
  localparam int NP = 2;
  // one extra bit so MEM_DEPTH == 2^ADDR_WIDTH is representable
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  logic                wr_in;
  logic                wr_ok;
  logic [NB-1:0][7:0]  wr_old;
  logic [NB-1:0][7:0]  wr_new;

  assign wr_in  = {1'b0, WrAddr} < DEPTH;
  assign wr_ok  = WrEn & wr_in;
  assign wr_old = mem[WrAddr];

  // merged entry: strobed lanes from WrData, others from current contents
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign wr_new[i] = WrStrb[i] ? WrData[8*i +: 8] : wr_old[i];
  end

  // storage update; out-of-range writes are dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[WrAddr] <= wr_new;
    end
  end

  // out-of-range write flag, pulsed the cycle after the request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) WrErr <= 1'b0;
    else      WrErr <= WrEn & ~wr_in;
  end

  logic [NP-1:0]                 rd_en;
  logic [NP-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NP-1:0][MEM_WIDTH-1:0]  rd_q;
  logic [NP-1:0]                 rd_vld;
  logic [NP-1:0]                 rd_err;

  assign rd_en   = {RdEnB, RdEnA};
  assign rd_addr = {RdAddrB, RdAddrA};

  for (genvar p = 0; p < NP; p++) begin : g_rd
    logic                 hit;
    logic [MEM_WIDTH-1:0] lookup;

    assign hit = {1'b0, rd_addr[p]} < DEPTH;

    // read mux: entry, optional same-edge write forward, zero when out of range
    always_comb begin
      lookup = mem[rd_addr[p]];
`ifdef REGFILE_WR_BYPASS_EN
      if (wr_ok && rd_addr[p] == WrAddr) lookup = wr_new;
`endif
      if (!hit) lookup = '0;
    end

    regfile_rd_port #(.W(MEM_WIDTH)) u_rd (
      .clk   (clk),
      .rst   (rst),
      .en    (rd_en[p]),
      .oor   (~hit),
      .din   (lookup),
      .dout  (rd_q[p]),
      .valid (rd_vld[p]),
      .err   (rd_err[p])
    );
  end

  assign RdDataA  = rd_q[0];
  assign RdValidA = rd_vld[0];
  assign RdErrA   = rd_err[0];
  assign RdDataB  = rd_q[1];
  assign RdValidB = rd_vld[1];
  assign RdErrB   = rd_err[1];
endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench for register_file_2r1w, MEM_DEPTH = 12 so out-of-range
// addresses exist. Collision expectation follows REGFILE_WR_BYPASS_EN.
module tb_register_file_2r1w;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        WrEn = 1'b0;
  logic [3:0]  WrAddr = '0;
  logic [3:0]  WrStrb = '0;
  logic [31:0] WrData = '0;
  logic        WrErr;
  logic        RdEnA = 1'b0, RdEnB = 1'b0;
  logic [3:0]  RdAddrA = '0, RdAddrB = '0;
  logic [31:0] RdDataA, RdDataB;
  logic        RdValidA, RdValidB, RdErrA, RdErrB;

  int n_assert = 0;
  int n_fail   = 0;

  register_file_2r1w #(.ADDR_WIDTH(4), .MEM_DEPTH(12), .MEM_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrStrb(WrStrb), .WrData(WrData), .WrErr(WrErr),
    .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdDataA(RdDataA), .RdValidA(RdValidA), .RdErrA(RdErrA),
    .RdEnB(RdEnB), .RdAddrB(RdAddrB), .RdDataB(RdDataB), .RdValidB(RdValidB), .RdErrB(RdErrB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle 1ns before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    WrEn = 1'b1; WrAddr = a; WrData = d; WrStrb = s;
  endtask

  logic [31:0] coll_exp;

  initial begin
`ifdef REGFILE_WR_BYPASS_EN
    coll_exp = 32'h5555FFFF;
`else
    coll_exp = 32'h0000AAAA;
`endif
    // reset state
    #12;
    chk("rst_rda", RdDataA, 32'h0);
    chk("rst_rdb", RdDataB, 32'h0);
    chk("rst_vld", {30'h0, RdValidB, RdValidA}, 32'h0);
    chk("rst_err", {29'h0, WrErr, RdErrB, RdErrA}, 32'h0);
    rst = 1'b1;

    // reset mid-cycle clears outputs and storage
    wr(4'd3, 32'hDEADBEEF, 4'hF);
    tick();
    WrEn = 1'b0; RdEnA = 1'b1; RdAddrA = 4'd3;
    tick();
    chk("pre_rst_data", RdDataA, 32'hDEADBEEF);
    chk("pre_rst_vld", {31'h0, RdValidA}, 32'h1);
    RdEnA = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_data", RdDataA, 32'h0);
    chk("async_rst_vld", {31'h0, RdValidA}, 32'h0);
    rst = 1'b1;
    RdEnA = 1'b1; RdAddrA = 4'd3;
    tick();
    chk("post_rst_data", RdDataA, 32'h0);
    chk("post_rst_vld", {31'h0, RdValidA}, 32'h1);
    RdEnA = 1'b0;
    tick();
    chk("post_rst_vld_drop", {31'h0, RdValidA}, 32'h0);

    // byte strobes
    wr(4'd5, 32'h11223344, 4'hF);
    tick();
    wr(4'd5, 32'hAABBCCDD, 4'b0101);
    tick();
    WrEn = 1'b0; RdEnA = 1'b1; RdAddrA = 4'd5;
    tick();
    chk("strb_merge", RdDataA, 32'h11BB33DD);

    // dual read with concurrent write
    RdEnA = 1'b0;
    wr(4'd1, 32'h1, 4'hF);
    tick();
    wr(4'd2, 32'h2, 4'hF);
    tick();
    RdEnA = 1'b1; RdAddrA = 4'd1; RdEnB = 1'b1; RdAddrB = 4'd2;
    wr(4'd7, 32'h9, 4'hF);
    tick();
    chk("dual_a", RdDataA, 32'h1);
    chk("dual_b", RdDataB, 32'h2);
    chk("dual_vld", {30'h0, RdValidB, RdValidA}, 32'h3);
    chk("dual_err", {29'h0, WrErr, RdErrB, RdErrA}, 32'h0);
    WrEn = 1'b0; RdEnB = 1'b0; RdAddrA = 4'd7;
    tick();
    chk("dual_wr_vis", RdDataA, 32'h9);
    chk("dual_b_hold", RdDataB, 32'h2);
    chk("dual_b_vld_drop", {31'h0, RdValidB}, 32'h0);

    // same-address read/write collision
    RdEnA = 1'b0;
    wr(4'd4, 32'h0000AAAA, 4'hF);
    tick();
    wr(4'd4, 32'h5555FFFF, 4'hF);
    RdEnA = 1'b1; RdAddrA = 4'd4;
    tick();
    chk("coll_same_edge", RdDataA, coll_exp);
    WrEn = 1'b0;
    tick();
    chk("coll_next", RdDataA, 32'h5555FFFF);

    // zero strobe write is a no-op without error
    RdEnA = 1'b0;
    wr(4'd5, 32'hFFFFFFFF, 4'h0);
    tick();
    chk("strb0_no_err", {31'h0, WrErr}, 32'h0);

    // out-of-range write then read
    wr(4'd13, 32'h1234, 4'hF);
    tick();
    chk("oor_wrerr", {31'h0, WrErr}, 32'h1);
    WrEn = 1'b0;
    RdEnA = 1'b1; RdAddrA = 4'd5; RdEnB = 1'b1; RdAddrB = 4'd13;
    tick();
    chk("oor_wrerr_drop", {31'h0, WrErr}, 32'h0);
    chk("oor_entry5", RdDataA, 32'h11BB33DD);
    chk("oor_rdb", RdDataB, 32'h0);
    chk("oor_flags", {28'h0, RdValidB, RdErrB, RdValidA, RdErrA}, 32'b1110);
    RdEnA = 1'b0; RdEnB = 1'b0;
    tick();
    chk("oor_flags_drop", {30'h0, RdValidB, RdErrB}, 32'h0);

    // hold while idle, even as the entry is rewritten
    RdEnA = 1'b1; RdAddrA = 4'd5;
    tick();
    chk("hold_base", RdDataA, 32'h11BB33DD);
    RdEnA = 1'b0;
    wr(4'd5, 32'hCAFEF00D, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_data", RdDataA, 32'h11BB33DD);
      chk("hold_vld", {31'h0, RdValidA}, 32'h0);
    end
    WrEn = 1'b0; RdEnA = 1'b1;
    tick();
    chk("hold_after", RdDataA, 32'hCAFEF00D);
    RdEnA = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/register_file_2r1w.md
# register_file_2r1w

Parametrised two-read/one-write register file with per-byte write strobes, registered read ports with valid pulses, and out-of-range address detection. It replaces the single-port, mutually exclusive read/write register file in the datapath wherever two operands must be fetched per cycle while a result is written back. All storage and read outputs are cleared on reset.

## Interface
- ADDR_WIDTH, 4, address width of all ports
- MEM_DEPTH, 16, number of entries; must satisfy 1 ≤ MEM_DEPTH ≤ 2^ADDR_WIDTH
- MEM_WIDTH, 32, entry width in bits; must be a multiple of 8
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- WrEn  input  1  write request
- WrAddr  input  ADDR_WIDTH  write address
- WrStrb  input  MEM_WIDTH/8  byte-lane write enables, bit i covers WrData[8i+7:8i]
- WrData  input  MEM_WIDTH  write data
- WrErr  output  1  one-cycle pulse: previous-cycle write addressed an entry ≥ MEM_DEPTH
- RdEnA / RdEnB  input  1  read request, port A / B
- RdAddrA / RdAddrB  input  ADDR_WIDTH  read address, port A / B
- RdDataA / RdDataB  output  MEM_WIDTH  registered read data
- RdValidA / RdValidB  output  1  one-cycle pulse: RdData updated this cycle
- RdErrA / RdErrB  output  1  one-cycle pulse, coincident with RdValid, when read address ≥ MEM_DEPTH

## Operation
- Reset (rst low, any time, asynchronous): every entry = 0; RdDataA/B = 0; RdValidA/B = 0; RdErrA/B = 0; WrErr = 0. Operations in flight are discarded; no write from the reset cycle lands.
- Write: WrEn high at edge with WrAddr < MEM_DEPTH updates only byte lanes whose WrStrb bit is 1; other lanes keep their value. WrStrb = 0 with WrEn high is a legal no-op (no WrErr).
- Out-of-range write (WrAddr ≥ MEM_DEPTH): storage unchanged, WrErr pulses next cycle.
- Read: RdEnX high at edge loads RdDataX with entry at RdAddrX, RdValidX pulses next cycle. Out-of-range read loads RdDataX = 0, RdValidX and RdErrX both pulse.
- RdEnX low: RdDataX holds last value, RdValidX = 0.
- Ports fully independent: WrEn, RdEnA, RdEnB may all be high in the same cycle, including identical addresses; A and B on the same address return identical data.
- Read/write same-address collision: behaviour per Configuration.

## Timing
- Write latency: storage updated at the edge sampling WrEn; visible to a read sampled at the following edge (1 cycle later).
- Read latency: 1 cycle; RdData/RdValid/RdErr registered, no combinational path from inputs to any output.
- Sustained throughput: one write and two reads every cycle, no stalls, no backpressure.
- First edge after rst deasserts is a normal operating edge.

## Configuration
- REGFILE_WR_BYPASS_EN defined: a read sampled at the same edge as a write to the same in-range address returns the post-write value (old entry with strobed lanes replaced by WrData), i.e. write-first.
- Undefined: same collision returns the pre-write value (read-first); new value visible from the next read onward.
- Out-of-range collisions unaffected by the macro (read returns 0, RdErr pulses).

## Test plan
- Reset: write 0xDEADBEEF to addr 3, assert rst low mid-cycle -> all outputs 0 immediately; read addr 3 after release -> RdDataA = 0x00000000, RdValidA pulses 1 cycle.
- Byte strobes: write 0x11223344 strb 4'b1111 to addr 5, then 0xAABBCCDD strb 4'b0101 -> read addr 5 returns 0x11BB33DD.
- Dual read + write: addr 1 = 0x1, addr 2 = 0x2; same cycle RdA addr 1, RdB addr 2, write 0x9 to addr 7 -> next cycle RdDataA = 0x1, RdDataB = 0x2, both valid; read addr 7 next cycle -> 0x9.
- Collision: addr 4 = 0x0000AAAA; same cycle write 0x5555FFFF strb 4'b1111 to addr 4 and RdA addr 4 -> RdDataA = 0x5555FFFF with REGFILE_WR_BYPASS_EN, 0x0000AAAA without; subsequent read = 0x5555FFFF in both builds.
- Out-of-range (MEM_DEPTH = 12): write 0x1234 to addr 13 -> WrErr pulses, no entry changes; RdB addr 13 -> RdDataB = 0, RdValidB and RdErrB pulse together.
- Hold: read addr 5 then deassert RdEnA for 3 cycles while writing addr 5 -> RdDataA holds old value, RdValidA stays 0.
